// File: rtl/cmt_queue_pkg.sv
// ============================================================================
// Module  : cmt_queue_pkg
// Brief   : Shared widths, opcode constants and retire-record type for the
//           commit queue.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package cmt_queue_pkg;

    localparam int BUS_64   = 64;
    localparam int BUS_32   = 32;
    localparam int BUS_RIDX = 5;

    localparam logic [6:0]        OPC_TRAP   = 7'h6b;
    localparam logic [6:0]        OPC_SYSTEM = 7'h73;
    localparam logic [BUS_32-1:0] INST_PUTCH = 32'h0000_007b;
    localparam logic [11:0]       CSR_MCYCLE = 12'hB00;

    typedef struct packed {
        logic [BUS_64-1:0]   pc;
        logic [BUS_32-1:0]   inst;
        logic [BUS_RIDX-1:0] rd;
        logic                rd_wen;
        logic [BUS_64-1:0]   rd_wdata;
        logic                skip;
    } cmt_rec_t;

    localparam int REC_W = $bits(cmt_rec_t);

    // Difftest cannot reproduce console output, device accesses or cycle counts.
    function automatic logic calc_skip(
        input logic [BUS_32-1:0] inst,
        input logic              mem_en,
        input logic [BUS_64-1:0] mem_addr,
        input logic [BUS_64-1:0] mmio_limit
    );
        logic w_putch;
        logic w_mmio;
        logic w_mcycle;
        w_putch  = (inst == INST_PUTCH);
        w_mmio   = mem_en && (mem_addr < mmio_limit);
        w_mcycle = (inst[6:0] == OPC_SYSTEM) && (inst[14:12] != 3'd0) &&
                   (inst[31:20] == CSR_MCYCLE);
        return w_putch || w_mmio || w_mcycle;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmtq_fifo.sv
// ============================================================================
// Module  : cmtq_fifo
// Brief   : Power-of-two record store with wrapping pointers, occupancy count
//           and a synchronous flush that overrides push and pop.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module cmtq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_count != C_DEPTH);
    assign w_do_pop  = i_pop && (r_count != '0);

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/cmt_queue.sv
// ============================================================================
// Module  : cmt_queue
// Brief   : Buffers writeback retire records and presents them one edge later
//           to the commit unit, tagging difftest skips and latching traps.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module cmt_queue
    import cmt_queue_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [63:0] MMIO_LIMIT = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [BUS_64-1:0]     i_pc,
    input  logic [BUS_32-1:0]     i_inst,
    input  logic [BUS_RIDX-1:0]   i_rd,
    input  logic                  i_rd_wen,
    input  logic [BUS_64-1:0]     i_rd_wdata,
    input  logic                  i_mem_en,
    input  logic [BUS_64-1:0]     i_mem_addr,
    output logic                  o_cmtvalid,
    output logic [BUS_64-1:0]     o_pc,
    output logic [BUS_32-1:0]     o_inst,
    output logic [BUS_RIDX-1:0]   o_rd,
    output logic                  o_rd_wen,
    output logic [BUS_64-1:0]     o_rd_wdata,
    output logic                  o_skipcmt,
    output logic                  o_trap,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    cmt_rec_t         w_push_rec;
    cmt_rec_t         w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;

    logic                r_cmtvalid;
    logic [BUS_64-1:0]   r_pc;
    logic [BUS_32-1:0]   r_inst;
    logic [BUS_RIDX-1:0] r_rd;
    logic                r_rd_wen;
    logic [BUS_64-1:0]   r_rd_wdata;
    logic                r_skipcmt;
    logic                r_trap;

    // x0 writes are architecturally dropped, so scrub them before storage.
    always_comb begin
        w_push_rec          = '0;
        w_push_rec.pc       = i_pc;
        w_push_rec.inst     = i_inst;
        w_push_rec.rd       = i_rd;
        w_push_rec.rd_wen   = i_rd_wen && (i_rd != '0);
        w_push_rec.rd_wdata = (i_rd != '0) ? i_rd_wdata : '0;
        w_push_rec.skip     = calc_skip(i_inst, i_mem_en, i_mem_addr, MMIO_LIMIT);
    end

    assign o_ready = (w_count < C_DEPTH) && !r_trap;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = (w_count != '0) && !r_trap;
    assign w_flush = w_pop && (w_head.inst[6:0] == OPC_TRAP);

    cmtq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (w_push_rec),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // Record fields hold between pops; only the valid strobe drops back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmtvalid <= 1'b0;
            r_pc       <= '0;
            r_inst     <= '0;
            r_rd       <= '0;
            r_rd_wen   <= 1'b0;
            r_rd_wdata <= '0;
            r_skipcmt  <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_cmtvalid <= w_pop;
            if (w_pop) begin
                r_pc       <= w_head.pc;
                r_inst     <= w_head.inst;
                r_rd       <= w_head.rd;
                r_rd_wen   <= w_head.rd_wen;
                r_rd_wdata <= w_head.rd_wdata;
                r_skipcmt  <= w_head.skip;
            end
            if (w_flush) begin
                r_trap <= 1'b1;
            end
        end
    end

    assign o_cmtvalid = r_cmtvalid;
    assign o_pc       = r_pc;
    assign o_inst     = r_inst;
    assign o_rd       = r_rd;
    assign o_rd_wen   = r_rd_wen;
    assign o_rd_wdata = r_rd_wdata;
    assign o_skipcmt  = r_skipcmt;
    assign o_trap     = r_trap;
    assign o_count    = w_count;

endmodule

`default_nettype wire

// File: tb/tb_cmt_queue.sv
// ============================================================================
// Module  : tb_cmt_queue
// Brief   : Directed vector bench for cmt_queue: single records, skip rules,
//           streaming order, mid-stream reset and trap flush.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_cmt_queue;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_pc;
    logic [31:0] i_inst;
    logic [4:0]  i_rd;
    logic        i_rd_wen;
    logic [63:0] i_rd_wdata;
    logic        i_mem_en;
    logic [63:0] i_mem_addr;
    logic        o_cmtvalid;
    logic [63:0] o_pc;
    logic [31:0] o_inst;
    logic [4:0]  o_rd;
    logic        o_rd_wen;
    logic [63:0] o_rd_wdata;
    logic        o_skipcmt;
    logic        o_trap;
    logic [2:0]  o_count;

    int n_checks = 0;
    int n_pass   = 0;

    cmt_queue dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_pc       (i_pc),
        .i_inst     (i_inst),
        .i_rd       (i_rd),
        .i_rd_wen   (i_rd_wen),
        .i_rd_wdata (i_rd_wdata),
        .i_mem_en   (i_mem_en),
        .i_mem_addr (i_mem_addr),
        .o_cmtvalid (o_cmtvalid),
        .o_pc       (o_pc),
        .o_inst     (o_inst),
        .o_rd       (o_rd),
        .o_rd_wen   (o_rd_wen),
        .o_rd_wdata (o_rd_wdata),
        .o_skipcmt  (o_skipcmt),
        .o_trap     (o_trap),
        .o_count    (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] wdata;
        logic        mem_en;
        logic [63:0] addr;
        logic        exp_wen;
        logic [63:0] exp_wdata;
        logic        exp_skip;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive_idle();
        i_valid    = 1'b0;
        i_pc       = '0;
        i_inst     = '0;
        i_rd       = '0;
        i_rd_wen   = 1'b0;
        i_rd_wdata = '0;
        i_mem_en   = 1'b0;
        i_mem_addr = '0;
    endtask

    task automatic drive_rec(input logic [63:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                             input logic wen, input logic [63:0] wdata,
                             input logic mem_en, input logic [63:0] addr);
        i_valid    = 1'b1;
        i_pc       = pc;
        i_inst     = inst;
        i_rd       = rd;
        i_rd_wen   = wen;
        i_rd_wdata = wdata;
        i_mem_en   = mem_en;
        i_mem_addr = addr;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmtvalid"}, 64'(o_cmtvalid), 64'd0);
        check({tag, "_pc"},       o_pc,            64'd0);
        check({tag, "_inst"},     64'(o_inst),     64'd0);
        check({tag, "_rd"},       64'(o_rd),       64'd0);
        check({tag, "_rd_wen"},   64'(o_rd_wen),   64'd0);
        check({tag, "_wdata"},    o_rd_wdata,      64'd0);
        check({tag, "_skip"},     64'(o_skipcmt),  64'd0);
        check({tag, "_trap"},     64'(o_trap),     64'd0);
        check({tag, "_count"},    64'(o_count),    64'd0);
    endtask

    // One push into an empty queue, then confirm the single-edge latency.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        drive_rec(v.pc, v.inst, v.rd, v.wen, v.wdata, v.mem_en, v.addr);
        @(negedge clk);
        drive_idle();
        check({tag, "_early_valid"}, 64'(o_cmtvalid), 64'd0);
        check({tag, "_count1"},      64'(o_count),    64'd1);
        @(negedge clk);
        check({tag, "_valid"}, 64'(o_cmtvalid), 64'd1);
        check({tag, "_pc"},    o_pc,            v.pc);
        check({tag, "_inst"},  64'(o_inst),     64'(v.inst));
        check({tag, "_rd"},    64'(o_rd),       64'(v.rd));
        check({tag, "_wen"},   64'(o_rd_wen),   64'(v.exp_wen));
        check({tag, "_wdata"}, o_rd_wdata,      v.exp_wdata);
        check({tag, "_skip"},  64'(o_skipcmt),  64'(v.exp_skip));
        check({tag, "_count0"}, 64'(o_count),   64'd0);
    endtask

    initial begin
        int exp_idx;
        vec_t v;

        //            pc                   inst          rd     wen   wdata                 mem   addr                  e_wen e_wdata               e_skip
        vecs[0] = '{64'h0000_0000_8000_0000, 32'h0010_0093, 5'd1,  1'b1, 64'h1,                1'b0, 64'h0,                1'b1, 64'h1,                1'b0};
        vecs[1] = '{64'h0000_0000_8000_0004, 32'h0002_b503, 5'd10, 1'b1, 64'h1234,             1'b1, 64'h0200_0000,        1'b1, 64'h1234,             1'b1};
        vecs[2] = '{64'h0000_0000_8000_0008, 32'h0002_b503, 5'd10, 1'b1, 64'h5678,             1'b1, 64'h8000_1000,        1'b1, 64'h5678,             1'b0};
        vecs[3] = '{64'h0000_0000_8000_000c, 32'hB000_2573, 5'd10, 1'b1, 64'h99,               1'b0, 64'h0,                1'b1, 64'h99,               1'b1};
        vecs[4] = '{64'h0000_0000_8000_0010, 32'h0550_0013, 5'd0,  1'b1, 64'h55,               1'b0, 64'h0,                1'b0, 64'h0,                1'b0};
        vecs[5] = '{64'h0000_0000_8000_0014, 32'h0000_007b, 5'd0,  1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 64'h0,                1'b1};
        vecs[6] = '{64'h0000_0000_8000_0018, 32'hC000_2573, 5'd10, 1'b1, 64'h7,                1'b0, 64'h0,                1'b1, 64'h7,                1'b0};
        vecs[7] = '{64'h0000_0000_8000_001c, 32'hB000_0073, 5'd0,  1'b0, 64'h0,                1'b0, 64'h0,                1'b0, 64'h0,                1'b0};
        vecs[8] = '{64'h0000_0000_8000_0020, 32'h0002_b023, 5'd0,  1'b0, 64'h0,                1'b1, 64'h7FFF_FFFF,        1'b0, 64'h0,                1'b1};
        vecs[9] = '{64'h0000_0000_8000_0024, 32'h0002_b583, 5'd11, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h8000_0000,   1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0};

        drive_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_ready", 64'(o_ready), 64'd1);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream: ten pushes must emerge in order, none lost.
        exp_idx = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (o_cmtvalid) begin
                check($sformatf("stream_pc%0d", exp_idx), o_pc, 64'h8000_1000 + 64'(4 * exp_idx));
                check($sformatf("stream_wdata%0d", exp_idx), o_rd_wdata, 64'hA5A5_0000 + 64'(exp_idx));
                check($sformatf("stream_rd%0d", exp_idx), 64'(o_rd), 64'((exp_idx % 31) + 1));
                exp_idx++;
            end
            check($sformatf("stream_count_cap%0d", c), 64'(o_count <= 3'd4), 64'd1);
            if (c < 10) begin
                check($sformatf("stream_ready%0d", c), 64'(o_ready), 64'd1);
                drive_rec(64'h8000_1000 + 64'(4 * c), 32'h0000_0013, 5'((c % 31) + 1),
                          1'b1, 64'hA5A5_0000 + 64'(c), 1'b0, 64'h0);
            end else begin
                drive_idle();
            end
        end
        check("stream_commit_total", 64'(exp_idx), 64'd10);

        // Reset while records are in flight.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_rec(64'h8000_2000 + 64'(4 * c), 32'h0000_0013, 5'd3, 1'b1, 64'(c + 1), 1'b0, 64'h0);
        end
        @(negedge clk);
        check("midrst_pre_valid", 64'(o_cmtvalid), 64'd1);
        check("midrst_pre_count", 64'(o_count), 64'd1);
        drive_idle();
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        check_all_zero("midrst_hold");
        rst = 1'b1;
        v = vecs[0];
        run_vec(v, "postrst");

        // Trap in the middle of three back-to-back records.
        @(negedge clk);
        drive_rec(64'h100, 32'h0000_0013, 5'd1, 1'b1, 64'h11, 1'b0, 64'h0);
        @(negedge clk);
        drive_rec(64'h104, 32'h0000_006b, 5'd0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        check("trap_first_valid", 64'(o_cmtvalid), 64'd1);
        check("trap_first_pc", o_pc, 64'h100);
        check("trap_pre_trap", 64'(o_trap), 64'd0);
        check("trap_third_ready", 64'(o_ready), 64'd1);
        drive_rec(64'h108, 32'h0000_0013, 5'd2, 1'b1, 64'h22, 1'b0, 64'h0);
        @(negedge clk);
        drive_idle();
        check("trap_rec_valid", 64'(o_cmtvalid), 64'd1);
        check("trap_rec_pc", o_pc, 64'h104);
        check("trap_rec_inst", 64'(o_inst), 64'h6b);
        check("trap_set", 64'(o_trap), 64'd1);
        check("trap_flushed", 64'(o_count), 64'd0);
        check("trap_ready", 64'(o_ready), 64'd0);
        drive_rec(64'h10c, 32'h0000_0013, 5'd4, 1'b1, 64'h33, 1'b0, 64'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("trap_hold_valid%0d", c), 64'(o_cmtvalid), 64'd0);
            check($sformatf("trap_hold_pc%0d", c), o_pc, 64'h104);
            check($sformatf("trap_hold_ready%0d", c), 64'(o_ready), 64'd0);
            check($sformatf("trap_hold_count%0d", c), 64'(o_count), 64'd0);
            check($sformatf("trap_hold_sticky%0d", c), 64'(o_trap), 64'd1);
        end
        drive_idle();

        rst = 1'b0;
        #1;
        check("trap_reset_clear", 64'(o_trap), 64'd0);
        check("trap_reset_ready", 64'(o_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[3], "final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
